// File: rtl/blue_motion_pkg.sv
// Shared game definitions: vertical motion states, screen and sprite
// geometry, and the bit positions inside the collision flag vector.
package blue_motion_pkg;

    // Vertical motion state of a character sprite
    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } vstate_t;

    // Visible screen size in pixels
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Blue player sprite size in pixels
    localparam int BLUE_W = 47;
    localparam int BLUE_H = 41;

    // Bit indices inside the 4-bit collision flag vector
    localparam int COL_DOWN  = 0;
    localparam int COL_UP    = 1;
    localparam int COL_RIGHT = 2;
    localparam int COL_LEFT  = 3;

endpackage

// File: rtl/blue_motion.sv
// Motion controller for the blue player sprite: horizontal walking with
// screen clamping, plus a GROUND/RISE/FALL vertical state machine that
// models jumping and gravity. Everything advances once per frame tick.
module blue_motion
    import blue_motion_pkg::*;
#(
    parameter int X_INIT = 100,
    parameter int Y_INIT = 300,
    parameter int STEP_X = 2,
    parameter int JUMP_V = 8,
    parameter int GRAV   = 1,
    parameter int V_MAX  = 8,
    parameter int X_MAX  = SCREEN_W - BLUE_W,
    parameter int Y_MAX  = SCREEN_H - BLUE_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic [3:0] is_Collision,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic [1:0] state,
    output logic [3:0] vy,
    output logic       facing
);

    // Parameters sized to the arithmetic they take part in
    localparam logic [10:0] C_STEP_X = 11'(STEP_X);
    localparam logic [10:0] C_X_MAX  = 11'(X_MAX);
    localparam logic [9:0]  C_Y_MAX  = 10'(Y_MAX);
    localparam logic [9:0]  C_X_INIT = 10'(X_INIT);
    localparam logic [8:0]  C_Y_INIT = 9'(Y_INIT);
    localparam logic [3:0]  C_JUMP_V = 4'(JUMP_V);
    localparam logic [3:0]  C_GRAV   = 4'(GRAV);
    localparam logic [3:0]  C_V_MAX  = 4'(V_MAX);

    logic [9:0] r_x;
    logic [8:0] r_y;
    vstate_t    r_state;
    logic [3:0] r_vy;
    logic       r_facing;

    logic [9:0]  w_xNext;
    logic        w_facingNext;
    logic [8:0]  w_yNext;
    vstate_t     w_stateNext;
    logic [3:0]  w_vyNext;

    // Widened intermediates: the top bit catches overflow or borrow so
    // positions clamp instead of wrapping around the screen.
    logic [10:0] w_xSum;
    logic [10:0] w_xDiff;
    logic [9:0]  w_ySum;
    logic [9:0]  w_yDiff;
    logic [4:0]  w_vySum;

    assign w_xSum  = {1'b0, r_x} + C_STEP_X;
    assign w_xDiff = {1'b0, r_x} - C_STEP_X;
    assign w_ySum  = {1'b0, r_y} + {6'd0, r_vy};
    assign w_yDiff = {1'b0, r_y} - {6'd0, r_vy};
    assign w_vySum = {1'b0, r_vy} + {1'b0, C_GRAV};

    // Horizontal walking: one key at a time turns the sprite and steps it
    // unless a wall blocks that side; both or neither keys leave it alone.
    always_comb begin
        w_xNext      = r_x;
        w_facingNext = r_facing;
        if (key_right && !key_left) begin
            w_facingNext = 1'b1;
            if (!is_Collision[COL_RIGHT]) begin
                w_xNext = (w_xSum > C_X_MAX) ? C_X_MAX[9:0] : w_xSum[9:0];
            end
        end else if (key_left && !key_right) begin
            w_facingNext = 1'b0;
            if (!is_Collision[COL_LEFT]) begin
                w_xNext = w_xDiff[10] ? 10'd0 : w_xDiff[9:0];
            end
        end
    end

    // Vertical state machine: next state, speed and height for this frame
    always_comb begin
        w_stateNext = r_state;
        w_vyNext    = r_vy;
        w_yNext     = r_y;
        case (r_state)
            GROUND: begin
                if (key_jump && !is_Collision[COL_UP]) begin
                    w_stateNext = RISE;
                    w_vyNext    = C_JUMP_V;
                end else if (!is_Collision[COL_DOWN] && ({1'b0, r_y} < C_Y_MAX)) begin
                    w_stateNext = FALL;
                    w_vyNext    = 4'd0;
                end
            end
            RISE: begin
                if (is_Collision[COL_UP]) begin
                    w_stateNext = FALL;
                    w_vyNext    = 4'd0;
                end else if (w_yDiff[9]) begin
                    w_yNext     = 9'd0;
                    w_stateNext = FALL;
                    w_vyNext    = 4'd0;
                end else begin
                    w_yNext = w_yDiff[8:0];
                    if (r_vy <= C_GRAV) begin
                        w_stateNext = FALL;
                        w_vyNext    = 4'd0;
                    end else begin
                        w_vyNext = r_vy - C_GRAV;
                    end
                end
            end
            FALL: begin
                if (is_Collision[COL_DOWN]) begin
                    w_stateNext = GROUND;
                    w_vyNext    = 4'd0;
                end else if (w_ySum >= C_Y_MAX) begin
                    w_yNext     = C_Y_MAX[8:0];
                    w_stateNext = GROUND;
                    w_vyNext    = 4'd0;
                end else begin
                    w_yNext  = w_ySum[8:0];
                    w_vyNext = (w_vySum > {1'b0, C_V_MAX}) ? C_V_MAX : w_vySum[3:0];
                end
            end
            default: begin
                w_stateNext = FALL;
                w_vyNext    = 4'd0;
            end
        endcase
    end

    // Motion registers: reset wins over a tick, otherwise update once per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= C_X_INIT;
            r_y      <= C_Y_INIT;
            r_state  <= FALL;
            r_vy     <= 4'd0;
            r_facing <= 1'b1;
        end else if (frame_tick) begin
            r_x      <= w_xNext;
            r_y      <= w_yNext;
            r_state  <= w_stateNext;
            r_vy     <= w_vyNext;
            r_facing <= w_facingNext;
        end
    end

    assign x_blue = r_x;
    assign y_blue = r_y;
    assign state  = r_state;
    assign vy     = r_vy;
    assign facing = r_facing;

endmodule

// File: doc/blue_motion.md
# blue_motion

Per-character motion controller for the blue player sprite. Consumes the 4-bit collision flags produced by the collision detector, the player keys and a once-per-frame tick, and produces the sprite's top-left position (`x_blue`, `y_blue`) that feeds back into the collision detector and the renderer. It implements horizontal walking, jumping and gravity with a three-state vertical state machine.

## Interface
Parameters:
- `X_INIT`, 100, reset x position (pixels)
- `Y_INIT`, 300, reset y position (pixels)
- `STEP_X`, 2, horizontal pixels moved per frame
- `JUMP_V`, 8, initial upward speed (pixels/frame), 1..15
- `GRAV`, 1, speed change per frame
- `V_MAX`, 8, terminal falling speed, ≤15
- `X_MAX`, 593, rightmost x (640−47)
- `Y_MAX`, 439, lowest y (480−41), acts as screen floor

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse per video frame
- `key_left`, `key_right`, `key_jump`  in  1 each  player keys, level-sensitive
- `is_Collision`  in  4  bit0 down, bit1 up, bit2 right, bit3 left
- `x_blue`  out  10  sprite x
- `y_blue`  out  9  sprite y
- `state`  out  2  `GROUND`=0, `RISE`=1, `FALL`=2
- `vy`  out  4  current vertical speed magnitude
- `facing`  out  1  1 = right, 0 = left

## Operation
- All updates happen only in cycles with `frame_tick`=1; keys and `is_Collision` are sampled in that cycle only. Other cycles: all registers hold.
- Horizontal (independent of vertical state):
  - exactly one of `key_left`/`key_right` asserted; both or neither: no move, `facing` holds.
  - right: `facing`←1; if !bit2: x←min(x+`STEP_X`, `X_MAX`).
  - left: `facing`←0; if !bit3: x←max(x−`STEP_X`, 0), computed without wrap.
- Vertical FSM:
  - `GROUND`: if `key_jump` and !bit1 → `RISE`, vy←`JUMP_V`, y unchanged. Else if !bit0 and y<`Y_MAX` → `FALL`, vy←0. Else stay.
  - `RISE`: if bit1 → `FALL`, vy←0, y unchanged. Else if vy>y → y←0, `FALL`, vy←0. Else y←y−vy; if vy≤`GRAV` → `FALL`, vy←0, else vy←vy−`GRAV`. `key_jump` ignored.
  - `FALL`: if bit0 → `GROUND`, vy←0, y unchanged. Else if y+vy≥`Y_MAX` → y←`Y_MAX`, `GROUND`, vy←0. Else y←y+vy, vy←min(vy+`GRAV`, `V_MAX`).
- Arithmetic in 11-bit (x) / 10-bit (y) intermediates; no wrap-around in either direction.
- Encoding 3 unused: returns to `FALL`, vy←0 on next tick.

## Timing
- Reset values: `x_blue`=`X_INIT`, `y_blue`=`Y_INIT`, `state`=`FALL`, `vy`=0, `facing`=1.
- `rst` overrides `frame_tick` in the same cycle.
- Outputs registered; new values visible the cycle after the tick.
- Collision flags arrive one cycle after position changes; frames are ≥2 cycles apart, so each tick sees flags for the current position.
- Simultaneous horizontal and vertical updates in one tick are independent.

## Structure
- Shared game package: state encoding (`GROUND`/`RISE`/`FALL`), screen size 640×480, blue sprite size 47×41, collision bit indices (down/up/right/left).
- Single module; no sub-module required.

## Test plan
- Reset, then ticks with `is_Collision`=0, no keys → y = 300, 301, 303, 306…; vy saturates at 8; state `FALL`.
- `FALL` at y=300, tick with bit0=1 → `GROUND`, vy=0, y=300; further ticks hold.
- `GROUND` y=300, bit0=1, `key_jump` pulse on one tick → `RISE` vy=8; next 8 ticks y=292,285,279,274,270,267,265,264, then `FALL` vy=0.
- `RISE` with bit1 asserted on a tick → `FALL`, vy=0, y unchanged.
- x=592, `key_right` held, bit2=0 → x=593 and stays; with bit2=1 x holds, `facing`=1; x=1 with `key_left` → x=0, no wrap.
- `FALL` y=435, vy=8, no collision → y=439, `GROUND`; `rst` asserted together with a tick → reset values.
